// File: rtl/mc_core_pkg.sv
// Shared types and encodings for the mc_core_hs multicycle MIPS core.
package mc_core_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE,
    ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT
  } state_t;

  typedef enum logic [1:0] {ALUO_BTA, ALUO_IMM, ALUO_RR} aluout_sel_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Returns {known, alucontrol}; unknown functs report known=0.
  function automatic logic [3:0] funct_decode(input logic [5:0] funct);
    case (funct)
      F_ADD:   return {1'b1, ALU_ADD};
      F_SUB:   return {1'b1, ALU_SUB};
      F_AND:   return {1'b1, ALU_AND};
      F_OR:    return {1'b1, ALU_OR};
      F_SLT:   return {1'b1, ALU_SLT};
      default: return {1'b0, ALU_ADD};
    endcase
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] ctl);
    case (ctl)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mc_core_hs_ctrl.sv
// Control FSM for mc_core_hs: sequencing, memory handshake, wait timeout.
module mc_core_ctrl
  import mc_core_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        irwrite,
  output logic        datawrite,
  output logic        abwrite,
  output logic        aluout_en,
  output aluout_sel_t aluout_sel,
  output logic [2:0]  alucontrol,
  output logic        regwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic        pcbranch,
  output logic        jump,
  output logic        instr_done,
  output logic        halted
);

  state_t      state, nxt;
  logic        req_q, we_q, iord_q, done_q, halted_q;
  logic [31:0] wait_cnt;
  logic [3:0]  fdec;
  logic        funct_ok, handshake, timeout;

  assign fdec       = funct_decode(funct);
  assign funct_ok   = fdec[3];
  assign alucontrol = fdec[2:0];
  assign handshake  = req_q && mem_ready;
  assign timeout    = (MAX_WAIT != 0) && req_q && !mem_ready &&
                      (wait_cnt == MAX_WAIT - 1);

  always_comb begin
    nxt = state;
    case (state)
      FETCH:    if (handshake) nxt = DECODE; else if (timeout) nxt = HALT;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:   nxt = MEMADR;
          OP_RTYPE:       nxt = EXECUTE;
          OP_BEQ, OP_BNE: nxt = BRANCH;
          OP_ADDI:        nxt = ADDIEX;
          OP_J:           nxt = JUMP;
          default:        nxt = HALT;
        endcase
      end
      MEMADR:   nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (handshake) nxt = MEMWB; else if (timeout) nxt = HALT;
      MEMWRITE: if (handshake) nxt = FETCH; else if (timeout) nxt = HALT;
      EXECUTE:  nxt = funct_ok ? ALUWB : HALT;
      ADDIEX:   nxt = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: nxt = FETCH;
      HALT:     nxt = HALT;
      default:  nxt = FETCH;
    endcase
  end

  // Memory-side outputs are registered from the next state so they are
  // glitch-free and hold steady across wait cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      req_q    <= 1'b1;
      we_q     <= 1'b0;
      iord_q   <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= nxt;
      req_q    <= (nxt == FETCH) || (nxt == MEMREAD) || (nxt == MEMWRITE);
      we_q     <= (nxt == MEMWRITE);
      iord_q   <= (nxt == MEMREAD) || (nxt == MEMWRITE);
      done_q   <= nxt inside {MEMWB, ALUWB, BRANCH, ADDIWB, JUMP};
      halted_q <= halted_q || (nxt == HALT);
      wait_cnt <= (req_q && !mem_ready) ? wait_cnt + 32'd1 : '0;
    end
  end

  assign mem_req    = req_q && !reset;
  assign mem_we     = we_q && !reset;
  assign iord       = iord_q;
  assign irwrite    = (state == FETCH) && handshake;
  assign datawrite  = (state == MEMREAD) && handshake;
  assign abwrite    = (state == DECODE);
  assign aluout_en  = (state == DECODE) || (state == MEMADR) || (state == ADDIEX) ||
                      ((state == EXECUTE) && funct_ok);
  assign aluout_sel = (state == DECODE)  ? ALUO_BTA :
                      (state == EXECUTE) ? ALUO_RR  : ALUO_IMM;
  assign regwrite   = (state == MEMWB) || (state == ALUWB) || (state == ADDIWB);
  assign regdst     = (state == ALUWB);
  assign memtoreg   = (state == MEMWB);
  assign pcbranch   = (state == BRANCH) &&
                      (((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero));
  assign jump       = (state == JUMP);
  assign instr_done = !reset && (done_q || ((state == MEMWRITE) && handshake));
  assign halted     = halted_q;

endmodule

// File: rtl/mc_core_hs.sv
// Multicycle MIPS core with req/ready memory handshake: datapath plus control.
module mc_core_hs
  import mc_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_done,
  output logic        halted
);

  logic [31:0] a, b, aluout, data;
  logic [31:0] rf [32];
  logic [31:0] signimm, rd1, rd2, aluout_d, wd;
  logic [4:0]  rs, rt, rd, wa;
  logic        zero;

  logic        iord, irwrite, datawrite, abwrite, aluout_en;
  logic        regwrite, regdst, memtoreg, pcbranch, jump;
  aluout_sel_t aluout_sel;
  logic [2:0]  alucontrol;

  mc_core_ctrl #(.MAX_WAIT(MAX_WAIT)) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .op         (instr[31:26]),
    .funct      (instr[5:0]),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .irwrite    (irwrite),
    .datawrite  (datawrite),
    .abwrite    (abwrite),
    .aluout_en  (aluout_en),
    .aluout_sel (aluout_sel),
    .alucontrol (alucontrol),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .pcbranch   (pcbranch),
    .jump       (jump),
    .instr_done (instr_done),
    .halted     (halted)
  );

  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign signimm = {{16{instr[15]}}, instr[15:0]};
  assign rd1     = (rs == 5'd0) ? '0 : rf[rs];
  assign rd2     = (rt == 5'd0) ? '0 : rf[rt];
  assign zero    = ((a - b) == '0);
  assign wa      = regdst ? rd : rt;
  assign wd      = memtoreg ? data : aluout;

  assign mem_adr   = iord ? aluout : pc;
  assign mem_wdata = b;

  always_comb begin
    aluout_d = '0;
    case (aluout_sel)
      ALUO_BTA: aluout_d = pc + {signimm[29:0], 2'b00};
      ALUO_IMM: aluout_d = a + signimm;
      ALUO_RR:  aluout_d = alu(a, b, alucontrol);
      default:  aluout_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      instr  <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      data   <= '0;
    end else begin
      if (irwrite) begin
        instr <= mem_rdata;
        pc    <= pc + 32'd4;
      end else if (pcbranch) begin
        pc <= aluout;
      end else if (jump) begin
        pc <= {pc[31:28], instr[25:0], 2'b00};
      end
      if (abwrite) begin
        a <= rd1;
        b <= rd2;
      end
      if (aluout_en) aluout <= aluout_d;
      if (datawrite) data <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (regwrite && (wa != 5'd0)) begin
      rf[wa] <= wd;
    end
  end

endmodule

// File: tb/tb_mc_core_hs.sv
// Directed self-checking bench for mc_core_hs with a wait-state memory model.
module tb_mc_core_hs;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FSLT = 6'b101010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, instr_done, halted;
  logic [31:0] mem_adr, mem_wdata, mem_rdata, pc, instr;

  logic [31:0] mem [1024];
  int unsigned wcnt = 0, wait_data = 0;

  int n_checks = 0, n_pass = 0;
  int cyc, n_done, last_done, n_wr, n_req, n_waitcyc, req_snap;
  logic [31:0] wr_adr, wr_data, wait_adr;
  logic in_wait, adr_moved;

  always #5 clk = ~clk;

  // Data region 0x40..0x7F inserts wait_data wait cycles per access.
  assign mem_rdata = mem[mem_adr[11:2]];
  assign mem_ready = !((mem_adr[31:6] == 26'h1) && (wcnt < wait_data));

  mc_core_hs #(.RESET_PC(32'h0000_0000), .MAX_WAIT(3)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .instr(instr),
    .instr_done(instr_done), .halted(halted)
  );

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [5:0] fn);
    return {6'b0, rs, rt, rd, 5'b0, fn};
  endfunction

  // One clock: observe mid-cycle, then update the memory model after the edge.
  task automatic clk_cycle();
    logic s_req, s_rdy, s_we;
    logic [31:0] s_adr, s_wd;
    @(negedge clk);
    s_req = mem_req; s_rdy = mem_ready; s_we = mem_we; s_adr = mem_adr; s_wd = mem_wdata;
    if (!reset) cyc++;
    if (instr_done) begin n_done++; last_done = cyc; end
    if (s_req) n_req++;
    if (s_req && s_rdy && s_we) begin n_wr++; wr_adr = s_adr; wr_data = s_wd; end
    if (s_req && !s_rdy) begin
      if (in_wait && (s_adr !== wait_adr)) adr_moved = 1'b1;
      in_wait = 1'b1; wait_adr = s_adr; n_waitcyc++;
    end else in_wait = 1'b0;
    @(posedge clk); #1;
    if (s_req && s_rdy && s_we) mem[s_adr[11:2]] = s_wd;
    if (s_req && !s_rdy) wcnt++; else wcnt = 0;
  endtask

  task automatic run(input int n);
    repeat (n) clk_cycle();
  endtask

  task automatic clear_counts();
    cyc = 0; n_done = 0; last_done = 0; n_wr = 0; n_req = 0; n_waitcyc = 0;
    wr_adr = '0; wr_data = '0; wait_adr = '0; in_wait = 1'b0; adr_moved = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    wait_data = 0; wcnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    clear_counts();
  endtask

  task automatic test_reset();
    clear_mem();
    mem[0] = ei(ADDI, 0, 1, 16'd5);
    clear_counts();
    reset = 1'b1;
    run(1);
    n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", mem_req); else n_pass++;
    n_checks++; if (instr_done !== 1'b0) $display("FAIL rst_done: got %b want 0", instr_done); else n_pass++;
    n_checks++; if (pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", pc); else n_pass++;
    n_checks++; if (instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", instr); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else n_pass++;
    reset = 1'b0; clear_counts();
    #1;
    n_checks++; if ({mem_req, mem_we, mem_adr} !== {2'b10, 32'h0})
      $display("FAIL rst_fetch: got req=%b we=%b adr=%h want 1 0 0", mem_req, mem_we, mem_adr); else n_pass++;
    run(1);
    n_checks++; if (instr !== ei(ADDI, 0, 1, 16'd5)) $display("FAIL rst_ir: got %h want %h", instr, ei(ADDI, 0, 1, 16'd5)); else n_pass++;
    n_checks++; if (pc !== 32'h4) $display("FAIL rst_pcinc: got %h want 4", pc); else n_pass++;
  endtask

  task automatic test_arith_mem();
    clear_mem();
    mem[0] = ei(ADDI, 0, 1, 16'd5);
    mem[1] = ei(ADDI, 0, 2, 16'd7);
    mem[2] = er(1, 2, 3, FADD);
    mem[3] = ei(SW, 0, 3, 16'h40);
    mem[4] = ei(LW, 0, 4, 16'h40);
    mem[5] = ei(SW, 0, 4, 16'h44);
    do_reset();
    run(12);
    n_checks++; if (n_done !== 3) $display("FAIL arith_ndone: got %0d want 3", n_done); else n_pass++;
    n_checks++; if (last_done !== 12) $display("FAIL arith_cycles: got %0d want 12", last_done); else n_pass++;
    n_checks++; if (pc !== 32'd12) $display("FAIL arith_pc: got %h want c", pc); else n_pass++;
    run(4);
    n_checks++; if (n_wr !== 1) $display("FAIL sw_count: got %0d want 1", n_wr); else n_pass++;
    n_checks++; if (wr_adr !== 32'h40) $display("FAIL sw_adr: got %h want 40", wr_adr); else n_pass++;
    n_checks++; if (wr_data !== 32'd12) $display("FAIL sw_data: got %h want c", wr_data); else n_pass++;
    n_checks++; if (last_done !== 16) $display("FAIL sw_cycles: got %0d want 16", last_done); else n_pass++;
    wait_data = 2;
    run(7);
    n_checks++; if (last_done !== 23) $display("FAIL lw_retire: got %0d want 23", last_done); else n_pass++;
    n_checks++; if (n_waitcyc !== 2) $display("FAIL lw_waits: got %0d want 2", n_waitcyc); else n_pass++;
    n_checks++; if ({adr_moved, wait_adr} !== {1'b0, 32'h40})
      $display("FAIL lw_adr_stable: got moved=%b adr=%h want 0 40", adr_moved, wait_adr); else n_pass++;
    wait_data = 0;
    run(4);
    n_checks++; if (mem[17] !== 32'd12) $display("FAIL lw_value: got %h want c", mem[17]); else n_pass++;
    n_checks++; if (n_wr !== 2) $display("FAIL lw_nwr: got %0d want 2", n_wr); else n_pass++;
  endtask

  task automatic test_branch_alu();
    clear_mem();
    mem[0]  = ei(ADDI, 0, 1, 16'd5);
    mem[1]  = ei(ADDI, 0, 2, 16'd7);
    mem[2]  = ei(BEQ, 1, 1, 16'd2);
    mem[3]  = ei(ADDI, 0, 2, 16'd100);
    mem[4]  = ei(ADDI, 0, 2, 16'd100);
    mem[5]  = ei(BNE, 1, 1, 16'd2);
    mem[6]  = er(1, 2, 5, FSUB);
    mem[7]  = er(5, 1, 6, FSLT);
    mem[8]  = ei(SW, 0, 5, 16'h48);
    mem[9]  = ei(SW, 0, 6, 16'h4C);
    mem[10] = ei(BNE, 1, 2, 16'd1);
    mem[11] = ei(ADDI, 0, 2, 16'd100);
    do_reset();
    run(11);
    n_checks++; if (pc !== 32'd20) $display("FAIL beq_pc: got %h want 14", pc); else n_pass++;
    n_checks++; if (last_done !== 11) $display("FAIL beq_cycles: got %0d want 11", last_done); else n_pass++;
    run(3);
    n_checks++; if (pc !== 32'd24) $display("FAIL bne_nt_pc: got %h want 18", pc); else n_pass++;
    run(16);
    n_checks++; if (mem[18] !== 32'hFFFF_FFFE) $display("FAIL sub_val: got %h want fffffffe", mem[18]); else n_pass++;
    n_checks++; if (mem[19] !== 32'd1) $display("FAIL slt_val: got %h want 1", mem[19]); else n_pass++;
    n_checks++; if (n_done !== 8) $display("FAIL br_ndone: got %0d want 8", n_done); else n_pass++;
    run(3);
    n_checks++; if (pc !== 32'd48) $display("FAIL bne_t_pc: got %h want 30", pc); else n_pass++;
  endtask

  task automatic test_jump_r0();
    clear_mem();
    mem[0]  = ei(ADDI, 0, 0, 16'd9);
    mem[1]  = ei(SW, 0, 0, 16'h54);
    mem[2]  = ei(ADDI, 0, 1, 16'd3);
    mem[3]  = ei(ADDI, 1, 1, 16'd1);
    mem[4]  = {J, 26'h40};
    mem[64] = ei(SW, 0, 1, 16'h58);
    mem[21] = 32'hDEAD_BEEF;
    do_reset();
    run(8);
    n_checks++; if (mem[21] !== 32'h0) $display("FAIL r0_zero: got %h want 0", mem[21]); else n_pass++;
    run(11);
    n_checks++; if (pc !== 32'h100) $display("FAIL j_pc: got %h want 100", pc); else n_pass++;
    n_checks++; if (last_done !== 19) $display("FAIL j_cycles: got %0d want 19", last_done); else n_pass++;
    run(4);
    n_checks++; if (mem[22] !== 32'd4) $display("FAIL j_target_exec: got %h want 4", mem[22]); else n_pass++;
  endtask

  task automatic test_illegal();
    clear_mem();
    mem[0] = ei(ADDI, 0, 1, 16'd1);
    mem[1] = 32'hFC00_0000;
    do_reset();
    run(5);
    n_checks++; if (halted !== 1'b0) $display("FAIL ill_early: got %b want 0", halted); else n_pass++;
    run(1);
    n_checks++; if (halted !== 1'b1) $display("FAIL ill_halted: got %b want 1", halted); else n_pass++;
    req_snap = n_req;
    run(20);
    n_checks++; if (n_req !== req_snap) $display("FAIL ill_req: got %0d req cycles want 0", n_req - req_snap); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL ill_sticky: got %b want 1", halted); else n_pass++;
    reset = 1'b1;
    run(1);
    n_checks++; if ({halted, pc} !== {1'b0, 32'h0}) $display("FAIL ill_reset: got halted=%b pc=%h want 0 0", halted, pc); else n_pass++;
    reset = 1'b0; clear_counts();
    run(1);
    n_checks++; if (pc !== 32'h4) $display("FAIL ill_restart: got %h want 4", pc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_mem();
    mem[0]  = ei(LW, 0, 1, 16'h40);
    mem[16] = 32'h0000_1234;
    mem[24] = 32'hFFFF_FFFF;
    wait_data = 10;
    do_reset();
    run(3);
    n_checks++; if ({mem_req, mem_ready, mem_adr} !== {2'b10, 32'h40})
      $display("FAIL mid_memread: got req=%b rdy=%b adr=%h want 1 0 40", mem_req, mem_ready, mem_adr); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL mid_req_now: got %b want 0", mem_req); else n_pass++;
    run(1);
    n_checks++; if ({mem_req, pc, instr} !== {1'b0, 64'h0})
      $display("FAIL mid_reset: got req=%b pc=%h ir=%h want 0 0 0", mem_req, pc, instr); else n_pass++;
    mem[0] = ei(SW, 0, 1, 16'h60);
    wait_data = 0;
    reset = 1'b0; clear_counts();
    run(4);
    n_checks++; if (mem[24] !== 32'h0) $display("FAIL mid_no_gpr: got %h want 0", mem[24]); else n_pass++;
  endtask

  task automatic test_timeout();
    clear_mem();
    mem[0] = ei(LW, 0, 1, 16'h40);
    wait_data = 100;
    do_reset();
    run(5);
    n_checks++; if ({halted, mem_req, mem_adr} !== {2'b01, 32'h40})
      $display("FAIL to_waiting: got halted=%b req=%b adr=%h want 0 1 40", halted, mem_req, mem_adr); else n_pass++;
    run(1);
    n_checks++; if ({halted, mem_req} !== 2'b10) $display("FAIL to_halt: got halted=%b req=%b want 1 0", halted, mem_req); else n_pass++;
    n_checks++; if (n_waitcyc !== 3) $display("FAIL to_waits: got %0d want 3", n_waitcyc); else n_pass++;
    req_snap = n_req;
    run(5);
    n_checks++; if (n_req !== req_snap) $display("FAIL to_req_idle: got %0d req cycles want 0", n_req - req_snap); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_arith_mem();
    test_branch_alu();
    test_jump_r0();
    test_illegal();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
